// File: rtl/mppt_regs_pkg.sv
// Shared register map, bit positions and reset defaults for the MPPT I2C register file.
package mppt_regs_pkg;

   localparam logic [7:0] ADDR_CTRL    = 8'h00;
   localparam logic [7:0] ADDR_STATUS  = 8'h01;
   localparam logic [7:0] ADDR_STEP_H  = 8'h02;
   localparam logic [7:0] ADDR_STEP_L  = 8'h03;
   localparam logic [7:0] ADDR_VMAX_H  = 8'h04;
   localparam logic [7:0] ADDR_VMAX_L  = 8'h05;
   localparam logic [7:0] ADDR_VMIN_H  = 8'h06;
   localparam logic [7:0] ADDR_VMIN_L  = 8'h07;
   localparam logic [7:0] ADDR_VREF_H  = 8'h08;
   localparam logic [7:0] ADDR_TEMP2_L = 8'h15;
   localparam logic [7:0] ADDR_LAST    = 8'h15;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_SRST_BIT = 1;
   localparam int CTRL_HOLD_BIT = 2;

   localparam int ST_RUN_BIT    = 0;
   localparam int ST_FAULT_BIT  = 1;
   localparam int ST_WRERR_BIT  = 2;
   localparam int ST_CFGERR_BIT = 3;
   localparam int ST_CFGOK_BIT  = 4;

   localparam logic [15:0] STEP_DEFAULT_C = 16'h0010;
   localparam logic [15:0] VMAX_DEFAULT_C = 16'hF000;
   localparam logic [15:0] VMIN_DEFAULT_C = 16'h1000;

endpackage

// File: rtl/mppt_reg16_stage.sv
// One byte-written 16-bit config register: MSB staging plus atomic commit on LSB write.
module mppt_reg16_stage
   import mppt_regs_pkg::*;
#(
   parameter logic [15:0] RESET_VAL = 16'h0000
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stage_wr_i,
   input  logic        stage_clr_i,
   input  logic        commit_wr_i,
   input  logic [7:0]  wdata_i,
   output logic [15:0] value_o,
   output logic [15:0] value_next_o
);

   logic [7:0]  stage_q, stage_d;
   logic        staged_q, staged_d;
   logic [15:0] value_q, value_d;

   // Stage the MSB; the LSB write merges it (or the live MSB) in one step.
   always_comb begin
      stage_d  = stage_q;
      staged_d = staged_q;
      value_d  = value_q;
      if (commit_wr_i) begin
         value_d  = {(staged_q ? stage_q : value_q[15:8]), wdata_i};
         stage_d  = 8'h00;
         staged_d = 1'b0;
      end else if (stage_wr_i) begin
         stage_d  = wdata_i;
         staged_d = 1'b1;
      end else if (stage_clr_i) begin
         stage_d  = 8'h00;
         staged_d = 1'b0;
      end else begin
         stage_d  = stage_q;
      end
   end

   // State register with synchronous reset to the default value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q  <= 8'h00;
         staged_q <= 1'b0;
         value_q  <= RESET_VAL;
      end else begin
         stage_q  <= stage_d;
         staged_q <= staged_d;
         value_q  <= value_d;
      end
   end

   assign value_o      = value_q;
   assign value_next_o = value_d;

endmodule

// File: rtl/mppt_i2c_regfile.sv
// MPPT configuration/monitor register file behind the I2C slave byte interface.
module mppt_i2c_regfile
   import mppt_regs_pkg::*;
#(
   parameter logic [15:0] STEP_DEFAULT = STEP_DEFAULT_C,
   parameter logic [15:0] VMAX_DEFAULT = VMAX_DEFAULT_C,
   parameter logic [15:0] VMIN_DEFAULT = VMIN_DEFAULT_C
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  reg_addr,
   input  logic [7:0]  reg_wdata,
   input  logic        reg_write,
   input  logic        reg_read,
   output logic [7:0]  reg_rdata,
   input  logic [15:0] v_ref,
   input  logic [15:0] pv_v,
   input  logic [15:0] pv_i,
   input  logic [15:0] bat_v,
   input  logic [15:0] bat_i,
   input  logic [15:0] temp1,
   input  logic [15:0] temp2,
   input  logic        mppt_running,
   input  logic        fault_in,
   output logic        mppt_en,
   output logic        hold,
   output logic        soft_rst,
   output logic [15:0] step_size,
   output logic [15:0] v_max,
   output logic [15:0] v_min,
   output logic        cfg_update,
   output logic        cfg_valid
);

   logic [7:0]  rdata_q, rdata_d;
   logic [15:0] shadow_q, shadow_d;
   logic [6:0]  shadow_idx_q, shadow_idx_d;
   logic        en_q, en_d, hold_q, hold_d, srst_q, srst_d, upd_q, upd_d;
   logic        fault_q, fault_d, wr_err_q, wr_err_d, cfg_err_q, cfg_err_d;

   logic        cfg_wr_s, commit_s, status_clr_s, wr_err_set_s, cfg_err_set_s;
   logic [15:0] step_s, vmax_s, vmin_s, step_nx_s, vmax_nx_s, vmin_nx_s;
   logic [15:0] rd_full_s;
   logic        rd_is16_s;
   logic [7:0]  ctrl_s, status_s, rd_byte_s;

   assign cfg_wr_s = reg_write && (reg_addr >= ADDR_STEP_H) && (reg_addr <= ADDR_VMIN_L);
   assign commit_s = cfg_wr_s && reg_addr[0];

   mppt_reg16_stage #(.RESET_VAL(STEP_DEFAULT)) u_step (
      .clk_i(clk), .rst_i(rst),
      .stage_wr_i(reg_write && (reg_addr == ADDR_STEP_H)), .stage_clr_i(cfg_wr_s),
      .commit_wr_i(reg_write && (reg_addr == ADDR_STEP_L)), .wdata_i(reg_wdata),
      .value_o(step_s), .value_next_o(step_nx_s)
   );

   mppt_reg16_stage #(.RESET_VAL(VMAX_DEFAULT)) u_vmax (
      .clk_i(clk), .rst_i(rst),
      .stage_wr_i(reg_write && (reg_addr == ADDR_VMAX_H)), .stage_clr_i(cfg_wr_s),
      .commit_wr_i(reg_write && (reg_addr == ADDR_VMAX_L)), .wdata_i(reg_wdata),
      .value_o(vmax_s), .value_next_o(vmax_nx_s)
   );

   mppt_reg16_stage #(.RESET_VAL(VMIN_DEFAULT)) u_vmin (
      .clk_i(clk), .rst_i(rst),
      .stage_wr_i(reg_write && (reg_addr == ADDR_VMIN_H)), .stage_clr_i(cfg_wr_s),
      .commit_wr_i(reg_write && (reg_addr == ADDR_VMIN_L)), .wdata_i(reg_wdata),
      .value_o(vmin_s), .value_next_o(vmin_nx_s)
   );

   assign cfg_valid = (vmin_s < vmax_s) && (step_s != 16'h0000);

   // Select the 16-bit register addressed by the word index.
   always_comb begin
      rd_full_s = 16'h0000;
      rd_is16_s = 1'b1;
      case (reg_addr[7:1])
         7'd1:    rd_full_s = step_s;
         7'd2:    rd_full_s = vmax_s;
         7'd3:    rd_full_s = vmin_s;
         7'd4:    rd_full_s = v_ref;
         7'd5:    rd_full_s = pv_v;
         7'd6:    rd_full_s = pv_i;
         7'd7:    rd_full_s = bat_v;
         7'd8:    rd_full_s = bat_i;
         7'd9:    rd_full_s = temp1;
         7'd10:   rd_full_s = temp2;
         default: rd_is16_s = 1'b0;
      endcase
   end

   // Read byte and all next-state logic; reads always see pre-write state.
   always_comb begin
      ctrl_s                 = 8'h00;
      ctrl_s[CTRL_EN_BIT]    = en_q;
      ctrl_s[CTRL_HOLD_BIT]  = hold_q;
      status_s               = 8'h00;
      status_s[ST_RUN_BIT]   = mppt_running;
      status_s[ST_FAULT_BIT] = fault_q;
      status_s[ST_WRERR_BIT] = wr_err_q;
      status_s[ST_CFGERR_BIT]= cfg_err_q;
      status_s[ST_CFGOK_BIT] = cfg_valid;

      if (reg_addr == ADDR_CTRL) begin
         rd_byte_s = ctrl_s;
      end else if (reg_addr == ADDR_STATUS) begin
         rd_byte_s = status_s;
      end else if (rd_is16_s && !reg_addr[0]) begin
         rd_byte_s = rd_full_s[15:8];
      end else if (rd_is16_s) begin
         rd_byte_s = (shadow_idx_q == reg_addr[7:1]) ? shadow_q[7:0] : rd_full_s[7:0];
      end else begin
         rd_byte_s = 8'h00;
      end

      rdata_d      = reg_read ? rd_byte_s : rdata_q;
      shadow_d     = shadow_q;
      shadow_idx_d = shadow_idx_q;
      if (reg_read && rd_is16_s && !reg_addr[0]) begin
         shadow_d     = rd_full_s;
         shadow_idx_d = reg_addr[7:1];
      end else begin
         shadow_d     = shadow_q;
      end

      en_d   = en_q;
      hold_d = hold_q;
      srst_d = 1'b0;
      if (reg_write && (reg_addr == ADDR_CTRL)) begin
         en_d   = reg_wdata[CTRL_EN_BIT];
         hold_d = reg_wdata[CTRL_HOLD_BIT];
         srst_d = reg_wdata[CTRL_SRST_BIT];
      end else begin
         srst_d = 1'b0;
      end

      upd_d         = commit_s;
      status_clr_s  = reg_read && (reg_addr == ADDR_STATUS);
      wr_err_set_s  = reg_write && ((reg_addr == ADDR_STATUS) || (reg_addr >= ADDR_VREF_H));
      cfg_err_set_s = commit_s && !((vmin_nx_s < vmax_nx_s) && (step_nx_s != 16'h0000));
      fault_d       = fault_in      | (fault_q   & !status_clr_s);
      wr_err_d      = wr_err_set_s  | (wr_err_q  & !status_clr_s);
      cfg_err_d     = cfg_err_set_s | (cfg_err_q & !status_clr_s);
   end

   // Register file state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q      <= 8'h00;
         shadow_q     <= 16'h0000;
         shadow_idx_q <= 7'd0;
         en_q         <= 1'b0;
         hold_q       <= 1'b0;
         srst_q       <= 1'b0;
         upd_q        <= 1'b0;
         fault_q      <= 1'b0;
         wr_err_q     <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         rdata_q      <= rdata_d;
         shadow_q     <= shadow_d;
         shadow_idx_q <= shadow_idx_d;
         en_q         <= en_d;
         hold_q       <= hold_d;
         srst_q       <= srst_d;
         upd_q        <= upd_d;
         fault_q      <= fault_d;
         wr_err_q     <= wr_err_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   assign reg_rdata  = rdata_q;
   assign mppt_en    = en_q;
   assign hold       = hold_q;
   assign soft_rst   = srst_q;
   assign cfg_update = upd_q;
   assign step_size  = step_s;
   assign v_max      = vmax_s;
   assign v_min      = vmin_s;

endmodule

// File: tb/tb_mppt_i2c_regfile.sv
// Scoreboard bench: a register-map model predicts every cycle's outputs, a monitor compares them.
module tb_mppt_i2c_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  reg_addr = 8'h00, reg_wdata = 8'h00, reg_rdata;
   logic        reg_write = 1'b0, reg_read = 1'b0;
   logic [15:0] live_v [7];
   logic [15:0] live_next [7];
   logic        run_v = 1'b0, run_next = 1'b0;
   logic        fault_in = 1'b0;
   logic        mppt_en, hold, soft_rst, cfg_update, cfg_valid;
   logic [15:0] step_size, v_max, v_min;

   typedef struct {
      logic [7:0]  rdata;
      logic        en, hold, srst, upd, cfgv;
      logic [15:0] step, vmax, vmin;
   } snap_t;

   snap_t exp_q[$];
   snap_t mon_e;
   int    n_checks = 0;
   int    n_errors = 0;

   // Reference model state: register map as plain arrays and flags.
   logic [15:0] m_cfg [3];
   bit          m_stg_ok;
   int          m_stg_k;
   logic [7:0]  m_stg_b;
   logic [15:0] m_shadow;
   int          m_shadow_k;
   bit          m_fault, m_wrerr, m_cfgerr, m_en, m_hold;
   logic [7:0]  m_rdata;

   mppt_i2c_regfile dut (
      .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata),
      .v_ref(live_v[0]), .pv_v(live_v[1]), .pv_i(live_v[2]), .bat_v(live_v[3]),
      .bat_i(live_v[4]), .temp1(live_v[5]), .temp2(live_v[6]),
      .mppt_running(run_v), .fault_in(fault_in),
      .mppt_en(mppt_en), .hold(hold), .soft_rst(soft_rst),
      .step_size(step_size), .v_max(v_max), .v_min(v_min),
      .cfg_update(cfg_update), .cfg_valid(cfg_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input int k);
      if (k >= 1 && k <= 3) return m_cfg[k-1];
      if (k >= 4 && k <= 10) return live_v[k-4];
      return 16'h0000;
   endfunction

   function automatic bit cfg_ok();
      return (m_cfg[2] < m_cfg[1]) && (m_cfg[0] != 16'h0000);
   endfunction

   // One clock of stimulus: drive inputs, advance the model, queue the expected outputs.
   task automatic cycle(input bit r, input bit wr, input bit rd, input logic [7:0] a,
                        input logic [7:0] d, input bit f);
      snap_t e;
      int    k;
      bit    clr, cfg_set, wr_set, srst, upd;
      @(negedge clk);
      rst = r; reg_write = wr; reg_read = rd; reg_addr = a; reg_wdata = d; fault_in = f;
      for (int i = 0; i < 7; i++) live_v[i] = live_next[i];
      run_v = run_next;
      srst = 1'b0; upd = 1'b0;
      if (r) begin
         m_cfg[0] = 16'h0010; m_cfg[1] = 16'hF000; m_cfg[2] = 16'h1000;
         m_stg_ok = 0; m_shadow = 16'h0000; m_shadow_k = 0;
         m_fault = 0; m_wrerr = 0; m_cfgerr = 0; m_en = 0; m_hold = 0; m_rdata = 8'h00;
      end else begin
         k = int'(a) / 2;
         if (rd) begin
            if (a == 8'h00) m_rdata = {5'b00000, m_hold, 1'b0, m_en};
            else if (a == 8'h01)
               m_rdata = {3'b000, cfg_ok(), m_cfgerr, m_wrerr, m_fault, run_v};
            else if (a <= 8'h15 && !a[0]) begin
               m_rdata = word_of(k) >> 8;
               m_shadow = word_of(k); m_shadow_k = k;
            end else if (a <= 8'h15)
               m_rdata = (m_shadow_k == k) ? m_shadow[7:0] : word_of(k) & 16'h00FF;
            else m_rdata = 8'h00;
         end
         clr = rd && (a == 8'h01);
         cfg_set = 0; wr_set = 0;
         if (wr) begin
            if (a == 8'h00) begin
               m_en = d[0]; m_hold = d[2]; srst = d[1];
            end else if (a >= 8'h02 && a <= 8'h07) begin
               if (!a[0]) begin
                  m_stg_ok = 1; m_stg_k = k - 1; m_stg_b = d;
               end else begin
                  m_cfg[k-1] = {((m_stg_ok && m_stg_k == k - 1) ? m_stg_b : m_cfg[k-1][15:8]), d};
                  m_stg_ok = 0; upd = 1'b1;
                  cfg_set = !cfg_ok();
               end
            end else wr_set = 1;
         end
         m_fault  = f       || (m_fault  && !clr);
         m_wrerr  = wr_set  || (m_wrerr  && !clr);
         m_cfgerr = cfg_set || (m_cfgerr && !clr);
      end
      e.rdata = m_rdata; e.en = m_en; e.hold = m_hold; e.srst = srst; e.upd = upd;
      e.step = m_cfg[0]; e.vmax = m_cfg[1]; e.vmin = m_cfg[2]; e.cfgv = cfg_ok();
      exp_q.push_back(e);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 8'h00, 8'h00, 0);
   endtask

   // Monitor: just after each edge, compare DUT outputs with the oldest prediction.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("reg_rdata",  {8'h00, reg_rdata}, {8'h00, mon_e.rdata});
         chk("mppt_en",    {15'h0, mppt_en},    {15'h0, mon_e.en});
         chk("hold",       {15'h0, hold},       {15'h0, mon_e.hold});
         chk("soft_rst",   {15'h0, soft_rst},   {15'h0, mon_e.srst});
         chk("cfg_update", {15'h0, cfg_update}, {15'h0, mon_e.upd});
         chk("cfg_valid",  {15'h0, cfg_valid},  {15'h0, mon_e.cfgv});
         chk("step_size",  step_size, mon_e.step);
         chk("v_max",      v_max,     mon_e.vmax);
         chk("v_min",      v_min,     mon_e.vmin);
      end
   end

   initial begin
      for (int i = 0; i < 7; i++) begin
         live_next[i] = 16'($urandom);
         live_v[i]    = live_next[i];
      end
      live_next[1] = 16'h0AFF;
      run_next = 1'b1;

      cycle(1, 0, 0, 8'h00, 8'h00, 0);
      cycle(1, 0, 0, 8'h00, 8'h00, 0);
      cycle(0, 0, 1, 8'h02, 8'h00, 0);
      cycle(0, 0, 1, 8'h03, 8'h00, 0);
      cycle(0, 0, 1, 8'h04, 8'h00, 0);
      cycle(0, 1, 0, 8'h04, 8'h12, 0);
      idle();
      cycle(0, 1, 0, 8'h05, 8'h34, 0);
      idle();
      idle();
      cycle(0, 0, 1, 8'h0A, 8'h00, 0);
      live_next[1] = 16'h0B00;
      idle();
      cycle(0, 0, 1, 8'h0B, 8'h00, 0);
      cycle(0, 1, 0, 8'h06, 8'hF0, 0);
      cycle(0, 1, 0, 8'h07, 8'h00, 0);
      idle();
      cycle(0, 0, 1, 8'h01, 8'h00, 0);
      cycle(0, 0, 1, 8'h01, 8'h00, 0);
      cycle(0, 1, 0, 8'h0C, 8'h55, 0);
      cycle(0, 0, 1, 8'h01, 8'h00, 1);
      cycle(0, 0, 1, 8'h01, 8'h00, 0);
      cycle(0, 1, 0, 8'h00, 8'h07, 0);
      idle();
      idle();
      cycle(0, 0, 1, 8'h00, 8'h00, 0);
      cycle(0, 1, 1, 8'h05, 8'h99, 0);
      cycle(0, 0, 1, 8'h05, 8'h00, 0);
      cycle(0, 0, 1, 8'h16, 8'h00, 0);
      cycle(0, 1, 0, 8'h02, 8'hAB, 0);
      cycle(1, 0, 0, 8'h00, 8'h00, 0);
      cycle(0, 1, 0, 8'h03, 8'h20, 0);
      idle();

      for (int n = 0; n < 800; n++) begin
         logic [7:0] a;
         if ($urandom_range(0, 19) == 0) live_next[$urandom_range(0, 6)] = 16'($urandom);
         run_next = 1'($urandom);
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 23));
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, a, 8'($urandom), $urandom_range(0, 9) == 0);
      end
      idle();

      repeat (2) @(posedge clk);
      #3;
      chk("queue_drained", 16'(exp_q.size()), 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mppt_i2c_regfile.md
Name: mppt_i2c_regfile

Overview:
- Register file directly downstream of the I2C slave.
- Decodes the slave's byte-wide reg_addr/reg_wdata/reg_write/reg_read strobes into the MPPT configuration/monitor register map.
- Returns reg_rdata to the slave and drives configuration outputs to the MPPT core.
- 16-bit registers are byte-accessed with atomic shadowing: coherent reads, glitch-free commits.

Parameters:
STEP_DEFAULT, 16'h0010, step_size reset value
VMAX_DEFAULT, 16'hF000, v_max reset value
VMIN_DEFAULT, 16'h1000, v_min reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
reg_addr  in  8  byte address from I2C slave
reg_wdata  in  8  write data
reg_write  in  1  one-cycle write strobe
reg_read  in  1  one-cycle read strobe
reg_rdata  out  8  read data to I2C slave
v_ref, pv_v, pv_i, bat_v, bat_i, temp1, temp2  in  16 each  live monitor values
mppt_running  in  1  live status from MPPT core
fault_in  in  1  fault event pulse/level
mppt_en  out  1  CTRL[0]
hold  out  1  CTRL[2]
soft_rst  out  1  one-cycle pulse from CTRL[1]
step_size, v_max, v_min  out  16 each  committed config
cfg_update  out  1  one-cycle pulse on any 16-bit commit
cfg_valid  out  1  (v_min < v_max) && (step_size != 0), combinational from committed regs

Behaviour:
- Single clock clk; reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values:
  - reg_rdata=0, mppt_en=0, hold=0, soft_rst=0, cfg_update=0.
  - step_size/v_max/v_min=defaults.
  - Sticky bits, shadow and staging cleared.
  - Reset mid-transaction discards any staged byte.
- Map:
  - 0x00 CTRL R/W: bit0 mppt_en, bit1 soft_rst (write-1 pulses soft_rst one cycle, reads 0), bit2 hold, bits7:3 read 0.
  - 0x01 STATUS R: bit0 mppt_running (live), bit1 fault (sticky), bit2 wr_err (sticky), bit3 cfg_err (sticky), bit4 cfg_valid (live).
  - 0x02/03 step_size, 0x04/05 v_max, 0x06/07 v_min: R/W.
  - 0x08..0x15 v_ref, pv_v, pv_i, bat_v, bat_i, temp1, temp2: R.
  - Even address = MSB, odd = LSB.
- Read:
  - reg_rdata registered, valid the cycle after reg_read, held until next reg_read.
  - Reading an even address of any 16-bit reg returns the MSB and captures the full 16-bit value into shadow + shadow_idx (addr[7:1]).
  - Reading the odd address returns shadow LSB if shadow_idx matches, else current LSB.
  - Unmapped (>=0x16) returns 0x00.
- Write:
  - MSB write to 0x02/04/06 stages byte + idx; output unchanged.
  - LSB write commits {staged MSB, wdata} if staged idx matches, else {current MSB, wdata}. Clears stage; pulses cfg_update the next cycle.
  - Commit producing v_min >= v_max or step_size == 0 still takes effect; sets cfg_err.
  - Write to a RO or unmapped address: ignored, sets wr_err.
- Sticky bits:
  - fault set whenever fault_in=1.
  - STATUS read returns pre-clear value, then clears fault/wr_err/cfg_err.
  - A set event in the same cycle as the clear wins (bit stays 1).
- reg_read and reg_write in the same cycle: both processed; read returns the pre-write value.
- No internal counters beyond staging/shadow; latency fixed at 1 cycle for reads and commits.

Decomposition:
- Package mppt_regs_pkg:
  - Address localparams (ADDR_CTRL..ADDR_TEMP2_L, ADDR_LAST=0x15).
  - CTRL/STATUS bit indices.
  - Default values.
- One sub-module natural: mppt_reg16_stage (MSB stage + LSB commit + reset default), instantiated three times.

Test Plan:
- After rst: read 0x02,0x03 -> 0x00,0x10; 0x04 -> 0xF0; cfg_valid=1; all outputs at reset values.
- Write 0x04=0x12 (v_max still 0xF000), then 0x05=0x34 -> v_max=0x1234 one cycle later, cfg_update pulses once.
- pv_v=0x0AFF, read 0x0A -> 0x0A; change pv_v to 0x0B00; read 0x0B -> 0xFF (shadow coherent).
- Write 0x06=0xF0, 0x07=0x00 (v_min=0xF000 >= v_max) -> cfg_valid=0. Read 0x01 -> bit3=1, bit4=0. Read 0x01 again -> bit3=0.
- Write 0x0C=0x55 -> ignored, wr_err set. fault_in pulse coincident with STATUS read -> fault bit still 1 on next read.
- Write 0x00=0x07 -> mppt_en=1, hold=1, soft_rst high exactly one cycle; read 0x00 -> 0x05. Assert rst after MSB stage of 0x02, then write 0x03=0x20 -> step_size=0x0020.
